// File: rtl/z80_bus_target.sv
// Z80 bus target: decodes Z80 memory/I/O cycles into backend requests, holds WAIT until ack or timeout.
// Optional interrupt-acknowledge support is enabled by defining Z80_TGT_INTACK_EN.
//
// state  | meaning
// IDLE   | waiting for a decodable Z80 cycle
// REQ    | backend request outstanding, WAIT asserted
// RDRIVE | read data driven until rd_n rises
// WHOLD  | write done, holding until wr_n rises
// INTA   | interrupt vector driven until iorq_n rises (Z80_TGT_INTACK_EN only)
module z80_bus_target #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic [15:0] addr,
  input  logic [7:0]  dbus_in,
  output logic [7:0]  dbus_out,
  output logic        dbus_oe,
  output logic        wait_n,
  output logic        req,
  output logic        req_io,
  output logic        req_we,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  input  logic        ack,
  input  logic [7:0]  rdata,
  input  logic [7:0]  int_vector,
  output logic        bus_err,
  input  logic        err_clr
);

`ifdef Z80_TGT_INTACK_EN
  typedef enum logic [2:0] {IDLE, REQ, RDRIVE, WHOLD, INTA} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, RDRIVE, WHOLD} state_t;
`endif

  state_t     state, state_d;
  logic [7:0] cnt;
  logic       armed;
  logic       all_high;
  logic       mem_rd, mem_wr, io_rd, io_wr;
  logic       latch_req, set_err, ld_rdata, ld_ff, ld_vec, cnt_inc;
  logic       oe_d;

  assign all_high = mreq_n & iorq_n & rd_n & wr_n & m1_n & rfsh_n;
  assign mem_rd   = !mreq_n && !rd_n && rfsh_n;
  assign mem_wr   = !mreq_n && !wr_n && rfsh_n;
  assign io_rd    = !iorq_n && m1_n && !rd_n;
  assign io_wr    = !iorq_n && m1_n && !wr_n;

  always_comb begin
    state_d   = state;
    latch_req = 1'b0;
    set_err   = 1'b0;
    ld_rdata  = 1'b0;
    ld_ff     = 1'b0;
    ld_vec    = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        // armed stays low after reset until the bus has been seen fully idle
        if (armed) begin
          if (!mreq_n && !iorq_n) begin
            set_err = 1'b1;
          end else if (mem_rd || mem_wr || io_rd || io_wr) begin
            state_d   = REQ;
            latch_req = 1'b1;
          end
`ifdef Z80_TGT_INTACK_EN
          else if (!iorq_n && !m1_n) begin
            state_d = INTA;
            ld_vec  = 1'b1;
          end
`endif
        end
      end
      REQ: begin
        if (ack) begin
          state_d  = req_we ? WHOLD : RDRIVE;
          ld_rdata = !req_we;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state_d = req_we ? WHOLD : RDRIVE;
          ld_ff   = !req_we;
          set_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RDRIVE: if (rd_n) state_d = IDLE;
      WHOLD:  if (wr_n) state_d = IDLE;
`ifdef Z80_TGT_INTACK_EN
      INTA:   if (iorq_n) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef Z80_TGT_INTACK_EN
  assign oe_d = (state_d == RDRIVE) || (state_d == INTA);
`else
  assign oe_d = (state_d == RDRIVE);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      armed     <= 1'b0;
      cnt       <= 8'd0;
      req       <= 1'b0;
      req_io    <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= 16'd0;
      req_wdata <= 8'd0;
      dbus_out  <= 8'd0;
      dbus_oe   <= 1'b0;
      wait_n    <= 1'b1;
      bus_err   <= 1'b0;
    end else begin
      state   <= state_d;
      armed   <= armed | all_high;
      req     <= (state_d == REQ);
      wait_n  <= (state_d != REQ);
      dbus_oe <= oe_d;
      if (latch_req)    cnt <= 8'd0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
      if (latch_req) begin
        req_addr  <= addr;
        req_io    <= !iorq_n;
        req_we    <= !wr_n;
        req_wdata <= dbus_in;
      end
      if (ld_rdata)    dbus_out <= rdata;
      else if (ld_ff)  dbus_out <= 8'hFF;
      else if (ld_vec) dbus_out <= int_vector;
      if (set_err)      bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed bench for z80_bus_target (TIMEOUT=4); inputs change and outputs are sampled 1ns after posedge.
module tb_z80_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [15:0] addr;
  logic [7:0]  dbus_in, dbus_out, rdata, int_vector, req_wdata;
  logic        dbus_oe, wait_n, req, req_io, req_we, ack, bus_err, err_clr;
  logic [15:0] req_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int req_rises = 0;
  int wait_lo   = 0;
  int snap_r, snap_w;
  logic req_q = 1'b0;

  z80_bus_target #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
    .addr(addr), .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe), .wait_n(wait_n),
    .req(req), .req_io(req_io), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .int_vector(int_vector), .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!wait_n) wait_lo <= wait_lo + 1;
    if (req && !req_q) req_rises <= req_rises + 1;
    req_q <= req;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfsh_n = 1;
  endtask

  initial begin
    rst = 1; bus_idle(); addr = 0; dbus_in = 0; rdata = 0; ack = 0;
    int_vector = 0; err_clr = 0;
    cyc(2);
    check("rst_req", req, 0);
    check("rst_wait_n", wait_n, 1);
    check("rst_oe", dbus_oe, 0);
    check("rst_err", bus_err, 0);
    check("rst_dout", dbus_out, 0);
    check("rst_raddr", req_addr, 0);
    rst = 0;
    cyc(1);

    // memory read, ack in second REQ cycle
    snap_r = req_rises; snap_w = wait_lo;
    mreq_n = 0; rd_n = 0; addr = 16'h0001;
    cyc(1);
    check("mrd_req", req, 1);
    check("mrd_we", req_we, 0);
    check("mrd_io", req_io, 0);
    check("mrd_addr", req_addr, 16'h0001);
    cyc(1);
    check("mrd_req2", req, 1);
    ack = 1; rdata = 8'h3E;
    cyc(1);
    ack = 0;
    check("mrd_req_drop", req, 0);
    check("mrd_dout", dbus_out, 8'h3E);
    check("mrd_oe", dbus_oe, 1);
    cyc(1);
    check("mrd_oe_hold", dbus_oe, 1);
    bus_idle();
    cyc(1);
    check("mrd_oe_off", dbus_oe, 0);
    check("mrd_wait_cnt", 16'(wait_lo - snap_w), 2);
    check("mrd_req_cnt", 16'(req_rises - snap_r), 1);

    // memory write, wr_n held 3 cycles after ack
    snap_r = req_rises;
    mreq_n = 0; wr_n = 0; addr = 16'hAA20; dbus_in = 8'h1D;
    cyc(1);
    check("mwr_addr", req_addr, 16'hAA20);
    check("mwr_wdata", req_wdata, 8'h1D);
    check("mwr_we", req_we, 1);
    ack = 1;
    cyc(1);
    ack = 0;
    cyc(3);
    check("mwr_hold_req", req, 0);
    bus_idle();
    cyc(2);
    check("mwr_req_cnt", 16'(req_rises - snap_r), 1);

    // refresh cycle ignored
    snap_r = req_rises; snap_w = wait_lo;
    mreq_n = 0; rfsh_n = 0; addr = 16'h0002;
    cyc(2);
    check("rfsh_req", req, 0);
    check("rfsh_wait_n", wait_n, 1);
    bus_idle();
    cyc(1);
    check("rfsh_req_cnt", 16'(req_rises - snap_r), 0);
    check("rfsh_wait_cnt", 16'(wait_lo - snap_w), 0);

    // I/O read with no ack: timeout after 4 cycles
    snap_w = wait_lo;
    iorq_n = 0; rd_n = 0; addr = 16'h12C4;
    cyc(1);
    check("iord_io", req_io, 1);
    check("iord_addr_hi", {8'h00, req_addr[15:8]}, 16'h0012);
    cyc(3);
    check("iord_req_4th", req, 1);
    cyc(1);
    check("to_req", req, 0);
    check("to_wait_n", wait_n, 1);
    check("to_dout", dbus_out, 8'hFF);
    check("to_oe", dbus_oe, 1);
    check("to_err", bus_err, 1);
    check("to_wait_cnt", 16'(wait_lo - snap_w), 4);
    bus_idle();
    cyc(1);
    check("to_oe_off", dbus_oe, 0);
    check("to_err_sticky", bus_err, 1);
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    check("err_clr", bus_err, 0);

    // interrupt acknowledge
    int_vector = 8'hFF;
    iorq_n = 0; m1_n = 0;
    cyc(1);
    check("inta_req", req, 0);
`ifdef Z80_TGT_INTACK_EN
    check("inta_oe", dbus_oe, 1);
    check("inta_dout", dbus_out, 8'hFF);
`else
    check("inta_oe", dbus_oe, 0);
`endif
    bus_idle();
    cyc(1);
    check("inta_oe_off", dbus_oe, 0);

    // mreq and iorq together: error, no request
    snap_r = req_rises;
    mreq_n = 0; iorq_n = 0; rd_n = 0;
    cyc(1);
    check("conf_err", bus_err, 1);
    check("conf_req", req, 0);
    bus_idle();
    cyc(1);
    check("conf_req_cnt", 16'(req_rises - snap_r), 0);
    err_clr = 1; mreq_n = 0; iorq_n = 0; rd_n = 0;
    cyc(1);
    check("conf_set_wins", bus_err, 1);
    bus_idle();
    cyc(1);
    err_clr = 0;
    check("conf_clr", bus_err, 0);

    // stray ack in IDLE ignored
    rdata = 8'h77; ack = 1;
    cyc(1);
    ack = 0;
    check("stray_req", req, 0);
    check("stray_oe", dbus_oe, 0);

    // reset during REQ, then a normal read with ack in the first REQ cycle
    mreq_n = 0; rd_n = 0; addr = 16'h0010;
    cyc(1);
    check("rr_req_on", req, 1);
    rst = 1;
    cyc(1);
    check("rr_req", req, 0);
    check("rr_wait_n", wait_n, 1);
    rst = 0;
    cyc(2);
    check("rr_no_redecode", req, 0);
    bus_idle();
    cyc(1);
    snap_w = wait_lo;
    mreq_n = 0; rd_n = 0; addr = 16'h4000;
    cyc(1);
    check("rr2_addr", req_addr, 16'h4000);
    ack = 1; rdata = 8'h5A;
    cyc(1);
    ack = 0;
    check("rr2_dout", dbus_out, 8'h5A);
    check("rr2_oe", dbus_oe, 1);
    check("rr2_wait_cnt", 16'(wait_lo - snap_w), 1);
    bus_idle();
    cyc(1);
    check("rr2_oe_off", dbus_oe, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/z80_bus_target.md
Z80_BUS_TARGET -- requirements
Module: z80_bus_target

Interface
REQ-001 SHALL have these ports; clock and reset first (name, direction, width, meaning):
- wb_clk_i, in, 1: single clock; the Z80 core runs on the same clock.
- wb_rst_i, in, 1: reset, synchronous, active-high.
- mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, in, 1 each: Z80 bus control strobes, active-low.
- addr, in, 16: Z80 address bus.
- dbus_in, in, 8: data driven by the Z80 during writes.
- dbus_out, out, 8: data returned to the Z80.
- dbus_oe, out, 1: high while dbus_out is to be driven onto the bus.
- wait_n, out, 1: Z80 WAIT input, active-low.
- req, out, 1: backend transfer request.
- req_io, out, 1: 1 = I/O space, 0 = memory space.
- req_we, out, 1: 1 = write, 0 = read.
- req_addr, out, 16: backend address.
- req_wdata, out, 8: backend write data.
- ack, in, 1: backend completion pulse.
- rdata, in, 8: backend read data, valid when ack=1.
- int_vector, in, 8: data byte returned on interrupt acknowledge.
- bus_err, out, 1: sticky error flag.
- err_clr, in, 1: clears bus_err.

REQ-002 SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for ack, range 1..255.

Function
REQ-003 SHALL implement the states IDLE, REQ, RDRIVE, WHOLD and INTA.
REQ-004 In IDLE, the block SHALL decode one sampled cycle as follows, with exactly one strobe pair low:
- mreq_n=0 & rd_n=0 & rfsh_n=1: memory read.
- mreq_n=0 & wr_n=0: memory write.
- iorq_n=0 & m1_n=1 & rd_n=0: I/O read.
- iorq_n=0 & m1_n=1 & wr_n=0: I/O write.
REQ-005 On decode, the block SHALL enter REQ on the next edge, with req=1 and req_addr, req_io, req_we and req_wdata latched from that sampled cycle.
- For I/O, req_addr[15:8] SHALL equal addr[15:8] as captured.
REQ-006 Refresh cycles (rfsh_n=0) SHALL be ignored: no req, wait_n stays 1.
REQ-007 wait_n SHALL be 0 in every cycle spent in REQ and 1 in all other states.
REQ-008 req SHALL remain high until ack=1 is sampled; ack arriving in the first REQ cycle is legal, giving a minimum latency of one REQ cycle.
REQ-009 Read ack: the block SHALL latch rdata into dbus_out, go to RDRIVE and set dbus_oe=1.
- dbus_oe SHALL stay 1 until rd_n=1 is sampled; the block then returns to IDLE with dbus_oe=0 on the next edge.
REQ-010 Write ack: the block SHALL go to WHOLD and return to IDLE once wr_n=1 is sampled, so that one Z80 cycle produces exactly one req.
REQ-011 A cycle counter SHALL start at 0 on entry to REQ.
- If it reaches TIMEOUT without ack, the block SHALL drop req and set bus_err=1.
- A read SHALL then complete via RDRIVE with dbus_out=8'hFF; a write SHALL complete via WHOLD.
REQ-012 If mreq_n=0 and iorq_n=0 are sampled together in IDLE, the block SHALL set bus_err=1, issue no req and remain in IDLE.
REQ-013 ack received outside REQ SHALL be ignored.
REQ-014 bus_err SHALL be cleared by err_clr=1. If set and clear coincide, set wins.
REQ-015 Outputs SHALL be registered; no combinational path from bus inputs to wait_n, dbus_oe or req.

Reset
REQ-016 With wb_rst_i=1 at a clock edge, the block SHALL go to IDLE with:
- req=0, req_io=0, req_we=0, req_addr=0, req_wdata=0
- dbus_out=0, dbus_oe=0, wait_n=1, bus_err=0, counter=0
REQ-017 Reset mid-transfer SHALL abort immediately: no further req and no completion. After release the block SHALL wait for all strobes to be high before decoding again.

Configuration
REQ-018 The macro Z80_TGT_INTACK_EN SHALL gate interrupt-acknowledge support.
- Defined: iorq_n=0 & m1_n=0 sampled in IDLE SHALL enter INTA, drive dbus_out=int_vector with dbus_oe=1 and no req, and return to IDLE when iorq_n=1 is sampled.
- Undefined: the INTA state SHALL be absent, interrupt-acknowledge cycles SHALL be ignored, and dbus_oe SHALL stay 0.

Verification
REQ-019 Memory read at addr 16'h0001, backend acks after 2 cycles with rdata=8'h3E -> one req pulse with req_we=0 and req_io=0; wait_n low for 2 cycles; dbus_out=8'h3E with dbus_oe=1 until rd_n rises.
REQ-020 Memory write of 8'h1D to 16'hAA20 -> req_addr=16'hAA20, req_wdata=8'h1D, req_we=1; exactly one req although wr_n stays low 3 cycles after ack.
REQ-021 Refresh cycle (mreq_n=0, rfsh_n=0, addr=16'h0002) -> req stays 0 and wait_n stays 1.
REQ-022 I/O read with TIMEOUT=4 and no ack -> req drops after 4 cycles; dbus_out=8'hFF; bus_err=1; err_clr pulse -> bus_err=0.
REQ-023 With Z80_TGT_INTACK_EN defined and int_vector=8'hFF: M1+IORQ cycle -> dbus_out=8'hFF with dbus_oe=1 and req=0. Without the macro, the same cycle leaves dbus_oe=0.
REQ-024 wb_rst_i asserted during REQ -> next edge gives req=0 and wait_n=1; a subsequent normal read completes correctly.
